// File: rtl/readout_pkg.sv
// Shared types and default widths for the serial readout receive path.
package readout_pkg;

    localparam int DEF_TIME_W = 16;
    localparam int DEF_CH_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TIME,
        ST_CH,
        ST_ERR
    } fsm_state_e;

    typedef struct packed {
        logic [DEF_TIME_W-1:0] ts;
        logic [DEF_CH_W-1:0]   ch;
    } rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock record FIFO; a push into a full FIFO is accepted only when a pop frees a slot that same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             push_acc
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_acc;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_acc  = pop & ~empty;
    assign push_acc = push & (~full | pop_acc);
    assign dout     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/serial_frame_capture.sv
// Deserializes strobed {timestamp, channel} frames from the readout link into a
// buffered valid/ready record stream, with sticky error/overflow flags.
module serial_frame_capture
    import readout_pkg::*;
#(
    parameter int TIME_W     = DEF_TIME_W,
    parameter int CH_W       = DEF_CH_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_in,
    input  logic              sl_time,
    input  logic              sl_ch,
    input  logic              sending_data,
    output logic [TIME_W-1:0] rec_time,
    output logic [CH_W-1:0]   rec_ch,
    output logic              rec_valid,
    input  logic              rec_ready,
    input  logic              err_clr,
    output logic              frame_err,
    output logic              overflow,
    output logic [7:0]        frame_cnt,
    output logic              busy
);

    localparam int TCW = $clog2(TIME_W + 1);
    localparam int CCW = $clog2(CH_W + 1);
    localparam logic [TCW-1:0] T_LAST = TCW'(TIME_W - 1);
    localparam logic [CCW-1:0] C_LAST = CCW'(CH_W - 1);

    fsm_state_e        state, state_nxt;
    logic [TCW-1:0]    t_cnt, t_cnt_nxt;
    logic [CCW-1:0]    c_cnt, c_cnt_nxt;
    logic              t_shift, c_shift, err_evt, push_nxt, bad_strobe;
    logic [TIME_W-1:0] time_sr;
    logic [CH_W-1:0]   ch_sr;
    logic              push_p1;
    logic              pop, fifo_full, fifo_empty, push_acc;
    logic [TIME_W+CH_W-1:0] head;

    assign bad_strobe = (sl_time & sl_ch) | (~sending_data & (sl_time | sl_ch));

    always_comb begin
        state_nxt = state;
        t_cnt_nxt = t_cnt;
        c_cnt_nxt = c_cnt;
        t_shift   = 1'b0;
        c_shift   = 1'b0;
        err_evt   = 1'b0;
        push_nxt  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bad_strobe || sl_ch) begin
                    err_evt = 1'b1;
                end else if (sl_time) begin
                    t_shift   = 1'b1;
                    t_cnt_nxt = TCW'(1);
                    c_cnt_nxt = '0;
                    state_nxt = (T_LAST == '0) ? ST_CH : ST_TIME;
                end
            end
            ST_TIME: begin
                if (bad_strobe || sl_ch || !sending_data) begin
                    err_evt = 1'b1;
                end else if (sl_time) begin
                    t_shift = 1'b1;
                    if (t_cnt == T_LAST) begin
                        c_cnt_nxt = '0;
                        state_nxt = ST_CH;
                    end else begin
                        t_cnt_nxt = t_cnt + TCW'(1);
                    end
                end
            end
            ST_CH: begin
                if (bad_strobe || sl_time || !sending_data) begin
                    err_evt = 1'b1;
                end else if (sl_ch) begin
                    c_shift = 1'b1;
                    if (c_cnt == C_LAST) begin
                        push_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        c_cnt_nxt = c_cnt + CCW'(1);
                    end
                end
            end
            ST_ERR: begin
                if (bad_strobe) begin
                    err_evt = 1'b1;
                end else if (!sending_data) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (err_evt) state_nxt = ST_ERR;
    end

    // Stage p0 -> p1: frame completion registered, record written one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            t_cnt     <= '0;
            c_cnt     <= '0;
            push_p1   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            t_cnt     <= t_cnt_nxt;
            c_cnt     <= c_cnt_nxt;
            push_p1   <= push_nxt;
            busy      <= (state_nxt != ST_IDLE);
            frame_err <= err_evt | (frame_err & ~err_clr);
            overflow  <= (push_p1 & ~push_acc) | (overflow & ~err_clr);
            if (push_acc) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (t_shift) time_sr <= {time_sr[TIME_W-2:0], serial_in};
        if (c_shift) ch_sr   <= {ch_sr[CH_W-2:0], serial_in};
    end

    assign pop = rec_valid & rec_ready;

    sync_fifo #(
        .WIDTH (TIME_W + CH_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_p1),
        .pop      (pop),
        .din      ({time_sr, ch_sr}),
        .dout     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .push_acc (push_acc)
    );

    assign rec_valid = ~fifo_empty;
    assign rec_time  = fifo_empty ? '0 : head[TIME_W+CH_W-1:CH_W];
    assign rec_ch    = fifo_empty ? '0 : head[CH_W-1:0];

endmodule

// File: tb/tb_serial_frame_capture.sv
// Bench for serial_frame_capture: table vectors, hand-written corner sequences and
// randomized traffic, all cross-checked every cycle against a frame-level model.
module tb_serial_frame_capture;
    import readout_pkg::*;

    localparam int TW = 16;
    localparam int CW = 7;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          serial_in = 1'b0;
    logic          sl_time = 1'b0;
    logic          sl_ch = 1'b0;
    logic          sending_data = 1'b0;
    logic          rec_ready = 1'b1;
    logic          err_clr = 1'b0;
    logic [TW-1:0] rec_time;
    logic [CW-1:0] rec_ch;
    logic          rec_valid, frame_err, overflow, busy;
    logic [7:0]    frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit rnd_ready = 0;
    bit rnd_clr   = 0;

    serial_frame_capture #(.TIME_W(TW), .CH_W(CW), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_in    (serial_in),
        .sl_time      (sl_time),
        .sl_ch        (sl_ch),
        .sending_data (sending_data),
        .rec_time     (rec_time),
        .rec_ch       (rec_ch),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .err_clr      (err_clr),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .frame_cnt    (frame_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Frame-level reference model: one running bit count and an integer accumulator.
    rec_t    q[$];
    int      m_mode = 0;        // 0 idle, 1 collecting, 2 waiting out a bad frame
    int      m_n = 0;
    longint  m_acc = 0;
    bit      m_pend = 0;
    rec_t    m_pend_rec;
    int      m_cnt = 0;
    bit      m_ovf = 0;
    bit      m_ferr = 0;

    task automatic model_reset();
        q.delete();
        m_mode = 0; m_n = 0; m_acc = 0; m_pend = 0;
        m_cnt = 0; m_ovf = 0; m_ferr = 0;
    endtask

    task automatic model_step(input bit sd, input bit st, input bit sc, input bit b,
                              input bit rdy, input bit clr);
        int  sz;
        bit  pop_now, set_ovf, set_err, bad, in_t;
        sz = q.size();
        pop_now = rdy && (sz > 0);
        set_ovf = 0;
        set_err = 0;
        if (pop_now) void'(q.pop_front());
        if (m_pend) begin
            if (sz < FD || pop_now) begin
                q.push_back(m_pend_rec);
                m_cnt = (m_cnt + 1) % 256;
            end else begin
                set_ovf = 1;
            end
        end
        m_pend = 0;
        bad = (st && sc) || (!sd && (st || sc));
        case (m_mode)
            0: begin
                if (bad || sc) set_err = 1;
                else if (st) begin m_acc = b; m_n = 1; m_mode = 1; end
            end
            1: begin
                in_t = (m_n < TW);
                if (bad || !sd || (in_t ? sc : st)) set_err = 1;
                else if (in_t ? st : sc) begin
                    m_acc = m_acc * 2 + b;
                    m_n++;
                    if (m_n == TW + CW) begin
                        m_pend = 1;
                        m_pend_rec.ts = TW'(m_acc / (1 << CW));
                        m_pend_rec.ch = CW'(m_acc % (1 << CW));
                        m_mode = 0;
                    end
                end
            end
            default: begin
                if (bad) set_err = 1;
                else if (!sd) m_mode = 0;
            end
        endcase
        if (set_err) m_mode = 2;
        m_ferr = set_err || (m_ferr && !clr);
        m_ovf  = set_ovf || (m_ovf && !clr);
    endtask

    always @(posedge clk) begin
        rec_t h;
        if (!rst_n) model_reset();
        else model_step(sending_data, sl_time, sl_ch, serial_in, rec_ready, err_clr);
        #1;
        h = (q.size() > 0) ? q[0] : '0;
        chk("mon_rec_valid", {31'b0, rec_valid}, {31'b0, (q.size() > 0)});
        chk("mon_rec_time", {16'b0, rec_time}, {16'b0, h.ts});
        chk("mon_rec_ch", {25'b0, rec_ch}, {25'b0, h.ch});
        chk("mon_frame_cnt", {24'b0, frame_cnt}, m_cnt);
        chk("mon_overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("mon_frame_err", {31'b0, frame_err}, {31'b0, m_ferr});
        chk("mon_busy", {31'b0, busy}, {31'b0, (m_mode != 0)});
    end

    task automatic cyc(input bit sd, input bit st, input bit sc, input bit b);
        @(negedge clk);
        sending_data = sd; sl_time = st; sl_ch = sc; serial_in = b;
        if (rnd_ready) rec_ready = $urandom_range(1, 0) == 1;
        if (rnd_clr)   err_clr = ($urandom_range(15, 0) == 0);
    endtask

    // fault 1: sl_ch after 10 time bits; fault 2: sending_data dropped after 3 channel bits
    task automatic send_frame(input logic [TW-1:0] t, input logic [CW-1:0] c,
                              input int pt, input int pc, input int fault);
        for (int i = 0; i < TW; i++) begin
            if (fault == 1 && i == 10) begin cyc(1, 0, 1, 1); return; end
            if (i == 5) repeat (pt) cyc(1, 0, 0, 0);
            cyc(1, 1, 0, t[TW-1-i]);
        end
        for (int j = 0; j < CW; j++) begin
            if (fault == 2 && j == 3) begin cyc(0, 0, 0, 0); return; end
            if (j == 2) repeat (pc) cyc(1, 0, 0, 0);
            cyc(1, 0, 1, c[CW-1-j]);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
    endtask

    typedef struct {
        logic [TW-1:0] t;
        logic [CW-1:0] c;
        int            pt;
        int            pc;
        int            fault;
        logic          ev;
        logic [TW-1:0] et;
        logic [CW-1:0] ec;
        logic          eerr;
    } vec_t;

    vec_t vt[7];
    int   exp_cnt;
    int   cnt0;

    initial begin
        vt[0] = '{16'hA5C3, 7'h55, 0, 0, 0, 1'b1, 16'hA5C3, 7'h55, 1'b0};
        vt[1] = '{16'hA5C3, 7'h55, 3, 2, 0, 1'b1, 16'hA5C3, 7'h55, 1'b0};
        vt[2] = '{16'h1234, 7'h7F, 0, 0, 1, 1'b0, 16'h0000, 7'h00, 1'b1};
        vt[3] = '{16'hBEEF, 7'h2A, 0, 0, 2, 1'b0, 16'h0000, 7'h00, 1'b1};
        vt[4] = '{16'hFFFF, 7'h7F, 0, 0, 0, 1'b1, 16'hFFFF, 7'h7F, 1'b0};
        vt[5] = '{16'h0000, 7'h00, 1, 1, 0, 1'b1, 16'h0000, 7'h00, 1'b0};
        vt[6] = '{16'h8001, 7'h41, 0, 0, 0, 1'b1, 16'h8001, 7'h41, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'b0, rec_valid}, 0);
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_cnt", {24'b0, frame_cnt}, 0);
        chk("reset_flags", {30'b0, frame_err, overflow}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Table: single frames with rec_ready held high
        exp_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            send_frame(vt[k].t, vt[k].c, vt[k].pt, vt[k].pc, vt[k].fault);
            cyc(0, 0, 0, 0);
            @(posedge clk); #1;
            if (vt[k].ev) exp_cnt++;
            chk($sformatf("vec%0d_valid", k), {31'b0, rec_valid}, {31'b0, vt[k].ev});
            chk($sformatf("vec%0d_time", k), {16'b0, rec_time}, {16'b0, vt[k].et});
            chk($sformatf("vec%0d_ch", k), {25'b0, rec_ch}, {25'b0, vt[k].ec});
            chk($sformatf("vec%0d_err", k), {31'b0, frame_err}, {31'b0, vt[k].eerr});
            chk($sformatf("vec%0d_cnt", k), {24'b0, frame_cnt}, exp_cnt);
            @(negedge clk) err_clr = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_pulse_end", k), {31'b0, rec_valid}, 0);
            chk($sformatf("vec%0d_err_clr", k), {31'b0, frame_err}, 0);
            @(negedge clk) err_clr = 1'b0;
        end

        // Overflow: five back-to-back frames with the consumer stalled
        cnt0 = exp_cnt;
        @(negedge clk) rec_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(16'h1000 + 16'(i), 7'(i), 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        @(posedge clk); #1;
        chk("ovf_flag", {31'b0, overflow}, 1);
        chk("ovf_cnt", {24'b0, frame_cnt}, (cnt0 + 4) % 256);
        chk("ovf_head_time", {16'b0, rec_time}, 32'h1001);
        chk("ovf_head_ch", {25'b0, rec_ch}, 1);
        @(negedge clk) rec_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("drain%0d_time", i), {16'b0, rec_time}, 32'h1000 + i);
            chk($sformatf("drain%0d_ch", i), {25'b0, rec_ch}, i);
        end
        @(posedge clk); #1;
        chk("drain_empty", {31'b0, rec_valid}, 0);
        pulse_clr();
        @(posedge clk); #1;
        chk("ovf_cleared", {31'b0, overflow}, 0);

        // Full FIFO with a pop on the push edge
        cnt0 = (cnt0 + 4) % 256;
        @(negedge clk) rec_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(16'h2000 + 16'(i), 7'(i + 8), 0, 0, 0);
        @(negedge clk);
        sending_data = 0; sl_time = 0; sl_ch = 0; serial_in = 0;
        rec_ready = 1'b1;
        @(posedge clk); #1;
        chk("fullpop_ovf", {31'b0, overflow}, 0);
        chk("fullpop_cnt", {24'b0, frame_cnt}, (cnt0 + 5) % 256);
        chk("fullpop_head", {16'b0, rec_time}, 32'h2002);
        repeat (5) @(posedge clk);
        #1;
        chk("fullpop_last_drained", {31'b0, rec_valid}, 0);

        // Reset in the middle of a timestamp word
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        sending_data = 0; sl_time = 0; serial_in = 0;
        @(posedge clk); #1;
        chk("rst_mid_valid", {31'b0, rec_valid}, 0);
        chk("rst_mid_busy", {31'b0, busy}, 0);
        chk("rst_mid_cnt", {24'b0, frame_cnt}, 0);
        chk("rst_mid_data", {9'b0, rec_time, rec_ch}, 0);
        @(negedge clk) rst_n = 1'b1;
        send_frame(16'h3C3C, 7'h3C, 0, 0, 0);
        cyc(0, 0, 0, 0);
        @(posedge clk); #1;
        chk("rst_after_valid", {31'b0, rec_valid}, 1);
        chk("rst_after_time", {16'b0, rec_time}, 32'h3C3C);
        chk("rst_after_ch", {25'b0, rec_ch}, 32'h3C);
        chk("rst_after_cnt", {24'b0, frame_cnt}, 1);
        repeat (3) cyc(0, 0, 0, 0);

        // Randomized traffic, checked by the model alone
        rnd_ready = 1;
        rnd_clr   = 1;
        for (int k = 0; k < 300; k++) begin
            int r;
            r = $urandom_range(9, 0);
            if (r == 0) begin
                repeat (6) cyc($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
                               $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);
                cyc(0, 0, 0, 0);
            end else begin
                send_frame(16'($urandom), 7'($urandom), $urandom_range(2, 0), $urandom_range(2, 0),
                           (r == 1) ? $urandom_range(2, 1) : 0);
                if ($urandom_range(1, 0) == 1) cyc(0, 0, 0, 0);
            end
        end
        rnd_ready = 0;
        rnd_clr   = 0;
        @(negedge clk);
        err_clr = 1'b0;
        rec_ready = 1'b1;
        repeat (8) cyc(0, 0, 0, 0);
        @(posedge clk); #2;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
